// File: rtl/fir_tcdm_mp_adapter.sv
// Multi-port TCDM master adapter: per-port 2-entry request skid buffer, outstanding
// credit limiting, combinational response path, sticky protocol-error flags.

module fir_tcdm_mp_lane #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int BYPASS    = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_req,
  output logic            in_gnt,
  input  logic [AW-1:0]   in_add,
  input  logic            in_wen,
  input  logic [DW/8-1:0] in_be,
  input  logic [DW-1:0]   in_data,
  output logic            tcdm_req,
  input  logic            tcdm_gnt,
  output logic [AW-1:0]   tcdm_add,
  output logic            tcdm_wen,
  output logic [DW/8-1:0] tcdm_be,
  output logic [DW-1:0]   tcdm_data,
  input  logic            tcdm_r_valid,
  output logic            busy,
  output logic            err
);
  localparam int CW = $clog2(MAX_OUTST+1);
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
  } req_t;

  req_t [1:0]  fifo_q;
  req_t        last_q, head, in_pl, out_pl;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  buf_cnt;
  logic [CW-1:0] out_cnt;
  logic        credit_ok, push, pop, hs;

  assign credit_ok = (SW'(buf_cnt) + SW'(out_cnt)) < SW'(MAX_OUTST);
  assign in_pl     = '{add: in_add, wen: in_wen, be: in_be, data: in_data};
  // last_q keeps the payload steady once the buffer drains
  assign head      = (buf_cnt != 2'd0) ? fifo_q[rd_ptr] : last_q;

  assign tcdm_req = ~rst_i & ((BYPASS != 0) ? (in_req & credit_ok) : (buf_cnt != 2'd0));
  assign in_gnt   = ~rst_i & credit_ok & ((BYPASS != 0) ? tcdm_gnt : (buf_cnt != 2'd2));
  assign out_pl   = (BYPASS != 0) ? in_pl : head;
  assign tcdm_add  = out_pl.add;
  assign tcdm_wen  = out_pl.wen;
  assign tcdm_be   = out_pl.be;
  assign tcdm_data = out_pl.data;

  assign hs   = tcdm_req & tcdm_gnt;
  assign push = (BYPASS == 0) & in_req & in_gnt;
  assign pop  = (BYPASS == 0) & hs;
  assign busy = (buf_cnt != 2'd0) | (out_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q  <= '0;
      last_q  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
      out_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= in_pl;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        last_q <= fifo_q[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      if (hs && !tcdm_r_valid)
        out_cnt <= out_cnt + 1'b1;
      else if (!hs && tcdm_r_valid) begin
        // a response with nothing outstanding is a protocol error; never underflow
        if (out_cnt == '0) err <= 1'b1;
        else               out_cnt <= out_cnt - 1'b1;
      end
    end
  end
endmodule

module fir_tcdm_mp_adapter #(
  parameter int MP        = 4,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int BYPASS    = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [MP-1:0]            in_req,
  output logic [MP-1:0]            in_gnt,
  input  logic [MP-1:0][AW-1:0]    in_add,
  input  logic [MP-1:0]            in_wen,
  input  logic [MP-1:0][DW/8-1:0]  in_be,
  input  logic [MP-1:0][DW-1:0]    in_data,
  output logic [MP-1:0][DW-1:0]    in_r_data,
  output logic [MP-1:0]            in_r_valid,
  output logic [MP-1:0]            tcdm_req,
  input  logic [MP-1:0]            tcdm_gnt,
  output logic [MP-1:0][AW-1:0]    tcdm_add,
  output logic [MP-1:0]            tcdm_wen,
  output logic [MP-1:0][DW/8-1:0]  tcdm_be,
  output logic [MP-1:0][DW-1:0]    tcdm_data,
  input  logic [MP-1:0][DW-1:0]    tcdm_r_data,
  input  logic [MP-1:0]            tcdm_r_valid,
  output logic                     busy_o,
  output logic [MP-1:0]            err_o
);
  if (DW % 8 != 0) begin : g_dw_chk
    $error("DW must be a multiple of 8");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > 15) begin : g_outst_chk
    $error("MAX_OUTST must be 1..15");
  end

  logic          rst;
  logic [MP-1:0] lane_busy;

  assign rst        = rst_i | clear_i;
  assign in_r_data  = tcdm_r_data;
  assign in_r_valid = tcdm_r_valid;

  for (genvar i = 0; i < MP; i++) begin : g_lane
    fir_tcdm_mp_lane #(
      .DW(DW), .AW(AW), .MAX_OUTST(MAX_OUTST), .BYPASS(BYPASS)
    ) u_lane (
      .clk_i        (clk_i),
      .rst_i        (rst),
      .in_req       (in_req[i]),
      .in_gnt       (in_gnt[i]),
      .in_add       (in_add[i]),
      .in_wen       (in_wen[i]),
      .in_be        (in_be[i]),
      .in_data      (in_data[i]),
      .tcdm_req     (tcdm_req[i]),
      .tcdm_gnt     (tcdm_gnt[i]),
      .tcdm_add     (tcdm_add[i]),
      .tcdm_wen     (tcdm_wen[i]),
      .tcdm_be      (tcdm_be[i]),
      .tcdm_data    (tcdm_data[i]),
      .tcdm_r_valid (tcdm_r_valid[i]),
      .busy         (lane_busy[i]),
      .err          (err_o[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst) busy_o <= 1'b0;
    else     busy_o <= |lane_busy;
  end
endmodule

// File: tb/tb_fir_tcdm_mp_adapter.sv
// Bench for fir_tcdm_mp_adapter: buffered and bypass instances, queue scoreboard
// reference model, directed scenarios plus randomized traffic.

module tb_fir_tcdm_mp_adapter;
  localparam int MP = 4, DW = 32, AW = 32, MAX_OUTST = 4, BW = DW/8;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst, clr;
  always #5 clk = ~clk;

  // buffered instance (a_*) and bypass instance (b_*)
  logic [MP-1:0] a_req, a_gnt, a_wen, a_rv, a_treq, a_tgnt, a_twen, a_trv, a_err;
  logic [MP-1:0][AW-1:0] a_add, a_tadd;
  logic [MP-1:0][BW-1:0] a_be, a_tbe;
  logic [MP-1:0][DW-1:0] a_data, a_rdata, a_tdata, a_trdata;
  logic a_busy;
  logic [MP-1:0] b_req, b_gnt, b_wen, b_rv, b_treq, b_tgnt, b_twen, b_trv, b_err;
  logic [MP-1:0][AW-1:0] b_add, b_tadd;
  logic [MP-1:0][BW-1:0] b_be, b_tbe;
  logic [MP-1:0][DW-1:0] b_data, b_rdata, b_tdata, b_trdata;
  logic b_busy;

  fir_tcdm_mp_adapter #(.MP(MP), .DW(DW), .AW(AW), .MAX_OUTST(MAX_OUTST), .BYPASS(0)) u_buf (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .in_req(a_req), .in_gnt(a_gnt), .in_add(a_add), .in_wen(a_wen), .in_be(a_be), .in_data(a_data),
    .in_r_data(a_rdata), .in_r_valid(a_rv),
    .tcdm_req(a_treq), .tcdm_gnt(a_tgnt), .tcdm_add(a_tadd), .tcdm_wen(a_twen), .tcdm_be(a_tbe),
    .tcdm_data(a_tdata), .tcdm_r_data(a_trdata), .tcdm_r_valid(a_trv),
    .busy_o(a_busy), .err_o(a_err));

  fir_tcdm_mp_adapter #(.MP(MP), .DW(DW), .AW(AW), .MAX_OUTST(MAX_OUTST), .BYPASS(1)) u_byp (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .in_req(b_req), .in_gnt(b_gnt), .in_add(b_add), .in_wen(b_wen), .in_be(b_be), .in_data(b_data),
    .in_r_data(b_rdata), .in_r_valid(b_rv),
    .tcdm_req(b_treq), .tcdm_gnt(b_tgnt), .tcdm_add(b_tadd), .tcdm_wen(b_twen), .tcdm_be(b_tbe),
    .tcdm_data(b_tdata), .tcdm_r_data(b_trdata), .tcdm_r_valid(b_trv),
    .busy_o(b_busy), .err_o(b_err));

  int vectors = 0, miscompares = 0;
  bit mon_en = 0, rnd_mode = 0, auto_rsp = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  req_t qa[MP][$];
  int   outa[MP], outb[MP];
  int   hs_a[MP], hs_b[MP], rvs_a[MP], rvs_b[MP];
  logic [MP-1:0] erra = '0, errb = '0;
  logic busya_exp = 1'b0, busyb_exp = 1'b0;

  // buffered-mode scoreboard: accepted requests queue per port, popped on downstream issue
  always @(negedge clk) if (mon_en) begin
    bit rs, any;
    rs = rst | clr;
    any = 0;
    chk("a_err", a_err, erra);
    chk("a_busy", a_busy, busya_exp);
    for (int p = 0; p < MP; p++) begin
      int n;
      bit cr, hs, push;
      n = qa[p].size();
      cr = (n + outa[p]) < MAX_OUTST;
      hs = a_treq[p] & a_tgnt[p];
      push = a_req[p] & a_gnt[p];
      chk("a_gnt", a_gnt[p], !rs && n < 2 && cr);
      chk("a_treq", a_treq[p], !rs && n != 0);
      chk("a_rvalid", a_rv[p], a_trv[p]);
      if (a_trv[p]) chk("a_rdata", a_rdata[p], a_trdata[p]);
      if (hs) begin
        if (n != 0) begin
          chk("a_order", {a_tadd[p], a_twen[p], a_tbe[p], a_tdata[p]}, qa[p][0]);
          void'(qa[p].pop_front());
        end
        hs_a[p]++;
      end
      any |= (n != 0) || (outa[p] != 0);
      if (rs) begin
        qa[p].delete();
        outa[p] = 0;
        erra[p] = 1'b0;
      end else begin
        if (push) qa[p].push_back(req_t'{a_add[p], a_wen[p], a_be[p], a_data[p]});
        if (hs && !a_trv[p]) outa[p]++;
        else if (!hs && a_trv[p]) begin
          if (outa[p] == 0) erra[p] = 1'b1;
          else outa[p]--;
        end
      end
    end
    busya_exp = rs ? 1'b0 : any;
  end

  // bypass-mode model: credit gating only, payload straight through
  always @(negedge clk) if (mon_en) begin
    bit rs, any;
    rs = rst | clr;
    any = 0;
    chk("b_err", b_err, errb);
    chk("b_busy", b_busy, busyb_exp);
    for (int p = 0; p < MP; p++) begin
      bit cr, hs;
      cr = outb[p] < MAX_OUTST;
      chk("b_treq", b_treq[p], !rs && b_req[p] && cr);
      chk("b_gnt", b_gnt[p], !rs && b_tgnt[p] && cr);
      chk("b_rvalid", b_rv[p], b_trv[p]);
      if (b_trv[p]) chk("b_rdata", b_rdata[p], b_trdata[p]);
      if (b_treq[p]) chk("b_pass", {b_tadd[p], b_twen[p], b_tbe[p], b_tdata[p]},
                         {b_add[p], b_wen[p], b_be[p], b_data[p]});
      hs = b_treq[p] & b_tgnt[p];
      if (hs) hs_b[p]++;
      any |= outb[p] != 0;
      if (rs) begin
        outb[p] = 0;
        errb[p] = 1'b0;
      end else if (hs && !b_trv[p]) outb[p]++;
      else if (!hs && b_trv[p]) begin
        if (outb[p] == 0) errb[p] = 1'b1;
        else outb[p]--;
      end
    end
    busyb_exp = rs ? 1'b0 : any;
  end

  // one clock; returns 1 time unit after the rising edge with new stimulus applied
  task automatic step();
    logic [MP-1:0] acc_a, acc_b;
    @(negedge clk);
    acc_a = a_req & a_gnt;
    acc_b = b_req & b_gnt;
    @(posedge clk);
    #1;
    if (rnd_mode) for (int p = 0; p < MP; p++) begin
      if (!(a_req[p] && !acc_a[p])) begin
        a_req[p] = $urandom_range(0, 3) != 0;
        a_add[p] = $urandom; a_wen[p] = $urandom_range(0, 1);
        a_be[p] = BW'($urandom); a_data[p] = $urandom;
      end
      if (!(b_req[p] && !acc_b[p])) begin
        b_req[p] = $urandom_range(0, 3) != 0;
        b_add[p] = $urandom; b_wen[p] = $urandom_range(0, 1);
        b_be[p] = BW'($urandom); b_data[p] = $urandom;
      end
      a_tgnt[p] = $urandom_range(0, 3) != 0;
      b_tgnt[p] = $urandom_range(0, 3) != 0;
    end
    if (auto_rsp) for (int p = 0; p < MP; p++) begin
      a_trdata[p] = $urandom;
      b_trdata[p] = $urandom;
      a_trv[p] = (hs_a[p] - rvs_a[p] > 0) && ($urandom_range(0, 2) != 0);
      b_trv[p] = (hs_b[p] - rvs_b[p] > 0) && ($urandom_range(0, 2) != 0);
      if (a_trv[p]) rvs_a[p]++;
      if (b_trv[p]) rvs_b[p]++;
    end
  endtask

  task automatic do_reset();
    a_trv = '0; b_trv = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < MP; p++) begin
      rvs_a[p] = hs_a[p];
      rvs_b[p] = hs_b[p];
    end
  endtask

  task automatic set_a(input int p, input logic [AW-1:0] add, input logic [DW-1:0] data);
    a_add[p] = add; a_wen[p] = 1'b0; a_be[p] = '1; a_data[p] = data;
  endtask

  initial begin
    int base;
    rst = 1'b1; clr = 1'b0;
    a_req = '0; a_add = '0; a_wen = '0; a_be = '0; a_data = '0; a_tgnt = '0; a_trv = '0; a_trdata = '0;
    b_req = '0; b_add = '0; b_wen = '0; b_be = '0; b_data = '0; b_tgnt = '0; b_trv = '0; b_trdata = '0;
    for (int p = 0; p < MP; p++) begin
      outa[p] = 0; outb[p] = 0; hs_a[p] = 0; hs_b[p] = 0; rvs_a[p] = 0; rvs_b[p] = 0;
    end
    step();
    mon_en = 1;
    step();
    rst = 1'b0;
    chk("rst_treq", a_treq, 4'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_err", a_err, 4'b0);
    chk("rst_tadd", a_tadd[0], 32'h0);

    // single read on port 0
    a_tgnt = '1;
    a_req[0] = 1'b1; a_add[0] = 32'h1000; a_wen[0] = 1'b1; a_be[0] = '1; a_data[0] = '0;
    #1 chk("rd_gnt", a_gnt[0], 1'b1);
    chk("rd_treq_early", a_treq[0], 1'b0);
    step();
    a_req[0] = 1'b0;
    #1 chk("rd_treq", a_treq[0], 1'b1);
    chk("rd_tadd", a_tadd[0], 32'h1000);
    step();
    a_trv[0] = 1'b1; a_trdata[0] = 32'hDEADBEEF; rvs_a[0]++;
    #1 chk("rd_rdata", a_rdata[0], 32'hDEADBEEF);
    chk("rd_rvalid", a_rv[0], 1'b1);
    step();
    a_trv[0] = 1'b0;
    step();
    chk("rd_busy_idle", a_busy, 1'b0);

    // backpressure on port 1
    a_tgnt = '0;
    a_req[1] = 1'b1; set_a(1, 32'hA0, 32'hAAAA);
    #1 chk("bp_gntA", a_gnt[1], 1'b1);
    step();
    set_a(1, 32'hB0, 32'hBBBB);
    #1 chk("bp_gntB", a_gnt[1], 1'b1);
    step();
    set_a(1, 32'hC0, 32'hCCCC);
    #1 chk("bp_full", a_gnt[1], 1'b0);
    chk("bp_headA", a_tadd[1], 32'hA0);
    step();
    #1 chk("bp_holdA", a_tadd[1], 32'hA0);
    chk("bp_full2", a_gnt[1], 1'b0);
    a_tgnt[1] = 1'b1;
    #1 chk("bp_issueA", a_tadd[1], 32'hA0);
    step();
    #1 chk("bp_issueB", a_tadd[1], 32'hB0);
    step();
    a_req[1] = 1'b0;
    #1 chk("bp_issueC", a_tadd[1], 32'hC0);
    step();
    auto_rsp = 1;
    repeat (8) step();
    auto_rsp = 0;
    a_trv = '0;

    // credit limit on port 0
    a_tgnt = '1;
    a_req[0] = 1'b1; set_a(0, 32'h2000, 32'h1234);
    base = hs_a[0];
    repeat (8) step();
    chk("cr_hs4", hs_a[0] - base, 4);
    chk("cr_block", a_gnt[0], 1'b0);
    a_trv[0] = 1'b1; rvs_a[0]++;
    step();
    a_trv[0] = 1'b0;
    base = hs_a[0];
    repeat (6) step();
    chk("cr_hs1", hs_a[0] - base, 1);
    a_req[0] = 1'b0;
    auto_rsp = 1;
    repeat (12) step();
    auto_rsp = 0;
    a_trv = '0;
    step();

    // spurious response on port 2
    a_trv[2] = 1'b1; a_trdata[2] = 32'h55AA;
    step();
    a_trv[2] = 1'b0;
    #1 chk("err_set", a_err, 4'b0100);
    repeat (3) step();
    chk("err_sticky", a_err, 4'b0100);

    // reset with two entries buffered on port 3
    a_tgnt = '0;
    a_req[3] = 1'b1; set_a(3, 32'h3000, 32'h1);
    step();
    set_a(3, 32'h3004, 32'h2);
    step();
    a_req[3] = 1'b0;
    #1 chk("rs_buffered", a_treq[3], 1'b1);
    do_reset();
    chk("rs_treq", a_treq, 4'b0);
    chk("rs_busy", a_busy, 1'b0);
    chk("rs_err", a_err, 4'b0);
    chk("rs_tadd", a_tadd[3], 32'h0);

    // soft clear drops a sticky error
    a_trv[1] = 1'b1;
    step();
    a_trv[1] = 1'b0;
    #1 chk("clr_errset", a_err, 4'b0010);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_err", a_err, 4'b0);

    // bypass: same-cycle request/grant, then credit gating
    b_tgnt = '0;
    b_req[1] = 1'b1; b_add[1] = 32'h40;
    #1 chk("byp_req_nogнt", b_treq[1], 1'b1);
    chk("byp_gnt0", b_gnt[1], 1'b0);
    b_req[1] = 1'b0;
    b_tgnt = '1;
    b_req[0] = 1'b1; b_add[0] = 32'h4000; b_data[0] = 32'h77;
    #1 chk("byp_treq", b_treq[0], 1'b1);
    chk("byp_gnt", b_gnt[0], 1'b1);
    base = hs_b[0];
    repeat (4) step();
    chk("byp_hs4", hs_b[0] - base, 4);
    chk("byp_block", b_treq[0], 1'b0);
    chk("byp_inreq", b_req[0], 1'b1);
    b_req[0] = 1'b0;
    auto_rsp = 1;
    repeat (12) step();

    // randomized traffic on all ports of both instances
    rnd_mode = 1;
    repeat (1000) step();
    rnd_mode = 0;
    a_req = '0; b_req = '0; a_tgnt = '1; b_tgnt = '1;
    repeat (40) step();
    auto_rsp = 0;
    a_trv = '0; b_trv = '0;
    repeat (2) step();
    chk("drain_a_busy", a_busy, 1'b0);
    chk("drain_b_busy", b_busy, 1'b0);
    chk("drain_a_err", a_err, 4'b0);
    chk("drain_b_err", b_err, 4'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_tcdm_mp_adapter.md
Name: fir_tcdm_mp_adapter

Overview:
- Parametrised multi-port TCDM master adapter for the FIR HWPE. It sits between the accelerator streamer's flattened TCDM master ports and the cluster interconnect.
- Adds per-port registered request buffering (2-entry skid), per-port outstanding-transaction credit limiting, and status/error reporting that the plain port-flattening wrapper lacks.
- Generalised in port count, data width, address width and outstanding depth. Optional bypass mode for latency-critical builds.

Parameters:
- MP, 4, number of TCDM master ports.
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 32, address width in bits.
- MAX_OUTST, 4, maximum transactions in flight per port (buffered plus awaiting r_valid); 1..15.
- BYPASS, 0, 1 = combinational request path with credit gating only, no skid buffer.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- in_req  in  MP  upstream request per port.
- in_gnt  out  MP  upstream grant.
- in_add  in  MP x AW  upstream address.
- in_wen  in  MP  1 = read, 0 = write.
- in_be  in  MP x DW/8  byte enables.
- in_data  in  MP x DW  write data.
- in_r_data  out  MP x DW  read data to upstream.
- in_r_valid  out  MP  response valid to upstream.
- tcdm_req  out  MP  downstream request.
- tcdm_gnt  in  MP  downstream grant.
- tcdm_add  out  MP x AW  downstream address.
- tcdm_wen  out  MP  downstream wen.
- tcdm_be  out  MP x DW/8  downstream byte enables.
- tcdm_data  out  MP x DW  downstream write data.
- tcdm_r_data  in  MP x DW  downstream read data.
- tcdm_r_valid  in  MP  downstream response valid.
- busy_o  out  1  any port has buffered or outstanding transactions.
- err_o  out  MP  sticky per-port protocol error.

Behaviour:
- All ports are independent; there is no cross-port arbitration.
- Reset / clear_i (synchronous, checked on every clk_i edge): skid buffers empty, outstanding counters 0, err_o 0.
  - Reset outputs: tcdm_req 0, tcdm_add/wen/be/data 0, in_gnt 0 during the reset cycle, busy_o 0.
  - Reset mid-operation discards buffered requests. r_valid for transactions already granted downstream is forwarded to upstream but flags err_o, because the counter is 0.
- Response path, both modes: in_r_data = tcdm_r_data and in_r_valid = tcdm_r_valid, combinational. The adapter adds no response latency.
- Per-port counters:
  - buf_cnt in 0..2.
  - out_cnt in 0..MAX_OUTST, width $clog2(MAX_OUTST+1).
  - credit_ok = (buf_cnt + out_cnt) < MAX_OUTST.
- out_cnt update:
  - +1 on a downstream handshake (tcdm_req & tcdm_gnt).
  - -1 on tcdm_r_valid.
  - Both in the same cycle: unchanged.
  - tcdm_r_valid while out_cnt == 0 (and no handshake that cycle): err_o set, out_cnt stays 0, never underflows.
  - err_o clears only on rst_i or clear_i.
- Every downstream handshake, read or write, is expected to produce exactly one tcdm_r_valid, at least 1 cycle later.
- Buffered mode (BYPASS=0), per port:
  - in_gnt = (buf_cnt < 2) & credit_ok. This does not depend on tcdm_gnt, so there is no combinational path from tcdm to in_gnt.
  - Upstream handshake (in_req & in_gnt): the request {add, wen, be, data} is pushed into a 2-entry FIFO.
  - tcdm_req = (buf_cnt != 0); tcdm_add/wen/be/data come from the FIFO head. The head is held stable while tcdm_req & !tcdm_gnt.
  - Downstream handshake pops the head.
  - Push and pop in the same cycle: buf_cnt unchanged, order preserved.
  - Latency: a request accepted upstream in cycle t is presented downstream in cycle t+1 at the earliest.
  - Full (buf_cnt == 2): in_gnt 0 and in_req is held by upstream.
  - Empty: tcdm_req 0 and tcdm_* payload holds its last value.
  - Throughput: 1 request/cycle per port when tcdm_gnt is 1 continuously and MAX_OUTST >= 3 with 1-cycle responses.
- Bypass mode (BYPASS=1), per port:
  - tcdm_req = in_req & credit_ok.
  - in_gnt = tcdm_gnt & credit_ok.
  - Payload passes through combinationally.
  - buf_cnt is always 0.
- busy_o is registered: the OR over all ports of (buf_cnt != 0 | out_cnt != 0), sampled from the previous cycle's state.

Test Plan:
- Single read, port 0, BYPASS=0:
  - Stimulus: in_req with add 0x1000, wen 1; tcdm_gnt 1; r_valid one cycle after grant with data 0xDEADBEEF.
  - Required: tcdm_req rises one cycle after in_gnt; in_r_data 0xDEADBEEF in the same cycle as tcdm_r_valid; busy_o returns to 0.
- Backpressure, BYPASS=0:
  - Stimulus: tcdm_gnt held 0; issue 3 back-to-back requests on port 1.
  - Required: 2 accepted, in_gnt then 0; tcdm_add stable on the first request; after tcdm_gnt goes 1, downstream issue order is A, B, then C.
- Credit limit, MAX_OUTST=4:
  - Stimulus: tcdm_gnt 1, responses withheld, continuous in_req.
  - Required: exactly 4 downstream handshakes then in_gnt 0; one r_valid re-enables exactly one further grant.
- Simultaneous events:
  - Stimulus: in the same cycle, push plus pop, and handshake plus r_valid.
  - Required: buf_cnt and out_cnt unchanged; no lost or duplicated request (scoreboard over 1000 random cycles with all MP=4 ports active).
- Error / reset:
  - Stimulus: tcdm_r_valid on port 2 with no outstanding transaction.
  - Required: err_o = 4'b0100, and it stays set.
  - Stimulus: rst_i for 1 cycle with 2 entries buffered.
  - Required: next cycle tcdm_req 0, busy_o 0, err_o 0.
- Bypass, BYPASS=1:
  - Required: tcdm_req follows in_req in the same cycle; with tcdm_gnt 1, in_gnt 1 in the same cycle; after 4 unanswered handshakes, tcdm_req is forced 0 while in_req stays 1.
